// File: rtl/bcd_to_binary_seq.sv
// Sequential 11-digit packed-BCD to 36-bit binary converter (reverse double-dabble, one bit per clock).
// Optional macro BCD2BIN_SATURATE_EN: clamp data to all ones when the value overflows 36 bits.
module bcd_to_binary_seq (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [3:0]  BCD0,
    input  logic [3:0]  BCD1,
    input  logic [3:0]  BCD2,
    input  logic [3:0]  BCD3,
    input  logic [3:0]  BCD4,
    input  logic [3:0]  BCD5,
    input  logic [3:0]  BCD6,
    input  logic [3:0]  BCD7,
    input  logic [3:0]  BCD8,
    input  logic [3:0]  BCD9,
    input  logic [3:0]  BCD10,
    output logic [35:0] data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        digit_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;

    localparam logic [5:0] LAST_ITER = 6'd36;

    logic [1:0]  state_q,     state_d;
    logic [43:0] bcd_sr_q,    bcd_sr_d;
    logic [36:0] bin_sr_q,    bin_sr_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [35:0] data_q,      data_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        overflow_q,  overflow_d;
    logic        digit_err_q, digit_err_d;

    logic [43:0] digits_in;
    logic [43:0] bcd_shift;
    logic [36:0] bin_next;
    logic        digit_bad;

    assign digits_in = {BCD10, BCD9, BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

    // One reverse double-dabble step: shift the pair right, then pull every digit >= 8 down by 3.
    always_comb begin
        bcd_shift = {1'b0, bcd_sr_q[43:1]};
        bin_next  = {bcd_sr_q[0], bin_sr_q[36:1]};
        for (int i = 0; i < 11; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
        digit_bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (digits_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bcd_sr_d    = bcd_sr_q;
        bin_sr_d    = bin_sr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        digit_err_d = digit_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_sr_d    = digits_in;
                    bin_sr_d    = '0;
                    cnt_d       = '0;
                    overflow_d  = 1'b0;
                    digit_err_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = digit_bad ? ERR : SHIFT;
                end
            end
            SHIFT: begin
                bcd_sr_d = bcd_shift;
                bin_sr_d = bin_next;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
`ifdef BCD2BIN_SATURATE_EN
                    data_d = bin_next[36] ? {36{1'b1}} : bin_next[35:0];
`else
                    data_d = bin_next[35:0];
`endif
                    overflow_d = bin_next[36];
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            ERR: begin
                data_d      = '0;
                digit_err_d = 1'b1;
                overflow_d  = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            bcd_sr_q    <= '0;
            bin_sr_q    <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_sr_q    <= bcd_sr_d;
            bin_sr_q    <= bin_sr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign data      = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases plus random digits against a decimal-arithmetic model.
module tb_bcd_to_binary_seq;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic [3:0]  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7, BCD8, BCD9, BCD10;
    logic [35:0] data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        digit_err;

    int          checks;
    int          errors;
    logic [35:0] last_exp_data;

    bcd_to_binary_seq dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3), .BCD4(BCD4), .BCD5(BCD5),
        .BCD6(BCD6), .BCD7(BCD7), .BCD8(BCD8), .BCD9(BCD9), .BCD10(BCD10),
        .data(data), .busy(busy), .done(done), .overflow(overflow), .digit_err(digit_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the digits as a decimal number, then apply the 36-bit rules.
    function automatic void model(input logic [43:0] d, output logic [35:0] e_data,
                                  output logic e_ovf, output logic e_derr, output int e_lat);
        longint unsigned v;
        logic [3:0]      n;
        bit              bad;
        v   = 0;
        bad = 0;
        for (int i = 10; i >= 0; i--) begin
            n = d[4*i +: 4];
            if (n > 4'd9) bad = 1;
            v = v * 10 + longint'(n);
        end
        if (bad) begin
            e_data = '0; e_ovf = 1'b0; e_derr = 1'b1; e_lat = 1;
        end else begin
            e_ovf  = (v >= 64'd68719476736);
            e_derr = 1'b0;
            e_lat  = 37;
`ifdef BCD2BIN_SATURATE_EN
            e_data = e_ovf ? {36{1'b1}} : v[35:0];
`else
            e_data = v[35:0];
`endif
        end
    endfunction

    task automatic setDigits(input logic [43:0] d);
        {BCD10, BCD9, BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0} = d;
    endtask

    task automatic applyStimulus(input logic [43:0] d);
        setDigits(d);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        setDigits('0);
    endtask

    task automatic waitDone(input int init, output int lat);
        lat = init;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic compareResult(input string tag, input logic [43:0] d, input int lat);
        logic [35:0] e_data;
        logic        e_ovf, e_derr;
        int          e_lat;
        model(d, e_data, e_ovf, e_derr, e_lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(e_lat));
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_data"}, 64'(data), 64'(e_data));
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'(e_ovf));
        checkOutput({tag, "_digit_err"}, 64'(digit_err), 64'(e_derr));
        checkOutput({tag, "_busy_low"}, 64'(busy), 64'd0);
        last_exp_data = e_data;
    endtask

    task automatic runCheck(input string tag, input logic [43:0] d);
        int lat;
        applyStimulus(d);
        checkOutput({tag, "_busy_high"}, 64'(busy), 64'd1);
        waitDone(0, lat);
        compareResult(tag, d, lat);
        @(posedge Clk); #1;
        checkOutput({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [43:0] d;
        int          mode;
        checks        = 0;
        errors        = 0;
        last_exp_data = '0;
        start         = 1'b0;
        setDigits('0);
        Rst_n         = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_data", 64'(data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_digit_err", 64'(digit_err), 64'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        runCheck("v12345", 44'h00000012345);
        checkOutput("v12345_literal", 64'(data), 64'h000003039);
        runCheck("max36", 44'h68719476735);
        checkOutput("max36_literal", 64'(data), 64'hFFFFFFFFF);
        runCheck("all9", 44'h99999999999);
        checkOutput("all9_overflow_literal", 64'(overflow), 64'd1);
`ifdef BCD2BIN_SATURATE_EN
        checkOutput("all9_literal", 64'(data), 64'hFFFFFFFFF);
`else
        checkOutput("all9_literal", 64'(data), 64'h74876E7FF);
`endif

        // start re-pulsed at cycle 10 is ignored; start on the done cycle is accepted
        applyStimulus(44'h12345678901);
        repeat (9) begin @(posedge Clk); #1; end
        setDigits(44'h99999999999);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        setDigits('0);
        checkOutput("repulse_data_hold", 64'(data), 64'(last_exp_data));
        checkOutput("repulse_busy", 64'(busy), 64'd1);
        waitDone(10, lat);
        compareResult("repulse", 44'h12345678901, lat);
        applyStimulus(44'h40000000007);
        waitDone(0, lat);
        compareResult("b2b", 44'h40000000007, lat);
        @(posedge Clk); #1;
        checkOutput("b2b_done_width", 64'(done), 64'd0);

        // reset mid-conversion aborts without a done pulse
        applyStimulus(44'h55555555555);
        repeat (20) begin @(posedge Clk); #1; end
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_data", 64'(data), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        Rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (done === 1'b1) pulses++;
        end
        checkOutput("midrst_no_done", 64'(pulses), 64'd0);
        runCheck("after_rst", 44'h00987654321);

        runCheck("bcd3_bad", 44'h0000000A123);
        checkOutput("bcd3_bad_literal", 64'(digit_err), 64'd1);

        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 5));
            for (int i = 0; i < 11; i++) begin
                if (mode == 0)      d[4*i +: 4] = 4'($urandom_range(0, 15));
                else if (mode == 1) d[4*i +: 4] = 4'($urandom_range(6, 9));
                else                d[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            runCheck($sformatf("rand%0d", n), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
